// File: rtl/matmul_apb_master_pkg.sv
// Shared definitions for the matmul APB master: state encoding, bus-width
// defaults shared with the matmul top, and the strobe-width derivation.
package matmul_apb_master_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_BUS_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // One strobe bit per matrix element carried on the bus.
    function automatic int max_dim(input int data_width, input int bus_width);
        return bus_width / data_width;
    endfunction

endpackage

// File: rtl/matmul_apb_master_timeout_counter.sv
// ACCESS-phase wait counter; only present when MATMUL_APB_TIMEOUT_EN is defined.
// limit_hit flags the enabled cycle that completes the LIMIT-th wait cycle.
`ifdef MATMUL_APB_TIMEOUT_EN
module apb_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CW'(1);
        end
    end

    assign limit_hit = count_en && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/matmul_apb_master.sv
// Converts single valid/ready commands into APB SETUP/ACCESS transfers and
// returns a one-cycle response. Optional ACCESS timeout: MATMUL_APB_TIMEOUT_EN.
module matmul_apb_master
    import matmul_apb_master_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int MAX_DIM       = max_dim(DATA_WIDTH, BUS_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  busy_i
);

    apb_state_e state;
    apb_state_e next_state;

    logic accept;
    logic complete;
    logic abandon;
    logic timeout;

    assign accept   = (state == IDLE) && cmd_valid_i && cmd_ready_o;
    assign complete = (state == ACCESS) && pready_i;
    assign abandon  = (state == ACCESS) && !pready_i && timeout;

`ifdef MATMUL_APB_TIMEOUT_EN
    apb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (accept),
        .count_en  ((state == ACCESS) && !pready_i),
        .limit_hit (timeout)
    );
`else
    // ACCESS waits for pready_i forever; the limit only shapes the interface.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (complete || abandon) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            pstrb_o     <= '0;
            pwdata_o    <= '0;
            paddr_o     <= '0;
        end else begin
            psel_o      <= (next_state == SETUP) || (next_state == ACCESS);
            penable_o   <= (next_state == ACCESS);
            rsp_valid_o <= (next_state == RESP);
            cmd_ready_o <= (next_state == IDLE) && !busy_i;
            if (accept) begin
                pwrite_o <= cmd_write_i;
                paddr_o  <= cmd_addr_i;
                pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
                pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
            end
            if (complete) begin
                rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                rsp_err_o   <= pslverr_i;
            end else if (abandon) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: a transaction-level model of expected
// APB transfers and responses is checked every cycle against the DUT.
module tb_matmul_apb_master;

    localparam int DW = 8;
    localparam int BW = 16;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam int MD = BW / DW;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [BW-1:0] cmd_wdata = '0;
    logic [MD-1:0] cmd_strb  = '0;
    logic          rsp_valid;
    logic [BW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [MD-1:0] pstrb;
    logic [BW-1:0] pwdata;
    logic [AW-1:0] paddr;
    logic          pready    = 1'b0;
    logic          pslverr   = 1'b0;
    logic [BW-1:0] prdata    = '0;
    logic          busy      = 1'b0;

    matmul_apb_master #(
        .DATA_WIDTH     (DW),
        .BUS_WIDTH      (BW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_strb_i  (cmd_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pstrb_o     (pstrb),
        .pwdata_o    (pwdata),
        .paddr_o     (paddr),
        .pready_i    (pready),
        .pslverr_i   (pslverr),
        .prdata_i    (prdata),
        .busy_i      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [MD-1:0] strb;
    } apb_t;

    typedef struct {
        logic [BW-1:0] rdata;
        logic          err;
    } rsp_t;

    apb_t exp_apb[$];
    rsp_t exp_rsp[$];

    int            total       = 0;
    int            bad         = 0;
    int            slave_waits = 0;
    logic [BW-1:0] slave_rdata = '0;
    logic          slave_err   = 1'b0;
    logic          busy_at_edge = 1'b0;
    logic [BW-1:0] last_rdata  = '0;
    logic          last_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Cycles from the acceptance cycle to the response cycle.
    function automatic int latency(input int waits);
`ifdef MATMUL_APB_TIMEOUT_EN
        if (waits >= TO) return TO + 2;
`endif
        return waits + 3;
    endfunction

    // Slave: inserts slave_waits wait cycles, junk on prdata/pslverr until ready.
    initial begin
        int acc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) acc++;
            else acc = 0;
            pready  = (acc > slave_waits);
            pslverr = pready ? slave_err : 1'b1;
            prdata  = pready ? slave_rdata : 16'hDEAD;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            busy_at_edge = busy;
        end
    end

    // Per-cycle comparison of DUT outputs against the expected-transaction queues.
    initial begin
        logic prev_psel = 1'b0;
        logic prev_rsp  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_psel", psel, 0);
                check("reset_penable", penable, 0);
                check("reset_rsp_valid", rsp_valid, 0);
                check("reset_cmd_ready", cmd_ready, 0);
                check("reset_rsp_rdata", rsp_rdata, 0);
                check("reset_rsp_err", rsp_err, 0);
                check("reset_paddr", paddr, 0);
                prev_psel  = 1'b0;
                prev_rsp   = 1'b0;
                last_rdata = '0;
                last_err   = 1'b0;
            end else begin
                if (psel) begin
                    check("apb_expected", exp_apb.size() > 0, 1);
                    if (exp_apb.size() > 0) begin
                        check("paddr", paddr, exp_apb[0].addr);
                        check("pwrite", pwrite, exp_apb[0].write);
                        check("pwdata", pwdata, exp_apb[0].wdata);
                        check("pstrb", pstrb, exp_apb[0].strb);
                        check("penable_phase", penable, prev_psel);
                    end
                end else begin
                    check("penable_idle", penable, 0);
                    if (prev_psel && exp_apb.size() > 0) void'(exp_apb.pop_front());
                end
                if (rsp_valid) begin
                    check("rsp_single_cycle", prev_rsp, 0);
                    check("rsp_with_psel", psel, 0);
                    check("rsp_expected", exp_rsp.size() > 0, 1);
                    if (exp_rsp.size() > 0) begin
                        rsp_t r;
                        r = exp_rsp.pop_front();
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_err", rsp_err, r.err);
                        last_rdata = r.rdata;
                        last_err   = r.err;
                    end
                end else begin
                    check("rsp_hold_rdata", rsp_rdata, last_rdata);
                    check("rsp_hold_err", rsp_err, last_err);
                end
                if (psel || rsp_valid || busy_at_edge) check("cmd_ready_blocked", cmd_ready, 0);
                prev_psel = psel;
                prev_rsp  = rsp_valid;
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                                 input logic [MD-1:0] strb, input int waits,
                                 input logic [BW-1:0] rdata, input logic err);
        apb_t a;
        rsp_t r;
        a.write = wr;
        a.addr  = addr;
        a.wdata = wr ? wdata : '0;
        a.strb  = wr ? strb : '0;
        r.rdata = wr ? '0 : rdata;
        r.err   = err;
`ifdef MATMUL_APB_TIMEOUT_EN
        if (waits >= TO) begin
            r.rdata = '0;
            r.err   = 1'b1;
        end
`endif
        exp_apb.push_back(a);
        exp_rsp.push_back(r);
        slave_waits = waits;
        slave_rdata = rdata;
        slave_err   = err;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_wdata   = wdata;
        cmd_strb    = strb;
        cmd_valid   = 1'b1;
    endtask

    task automatic wait_accept(output int waited);
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            check("accept_bound", cmd_ready, 1);
            report();
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic checkOutput(input int exp_lat);
        int n;
        @(negedge clk);
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        @(negedge clk);
        n = 2;
        while (!rsp_valid && n < 200) begin
            check("access_phase", psel & penable, 1);
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_bound", rsp_valid, 1);
            report();
        end
        check("latency", n, exp_lat);
    endtask

    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                          input logic [MD-1:0] strb, input int waits,
                          input logic [BW-1:0] rdata, input logic err, output int waited);
        @(posedge clk);
        #1;
        applyStimulus(wr, addr, wdata, strb, waits, rdata, err);
        wait_accept(waited);
        checkOutput(latency(waits));
    endtask

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog actual=running required=finished");
        report();
    end

    initial begin
        int w;
        int seen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", cmd_ready, 0);
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);

        $display("[TB] write, no wait states");
        do_cmd(1'b1, 32'h0000_0020, 16'hA55A, 2'b11, 0, 16'h0000, 1'b0, w);
        check("wr_rdata_lit", rsp_rdata, 16'h0000);
        check("wr_err_lit", rsp_err, 0);

        $display("[TB] read, three wait states, back-to-back");
        do_cmd(1'b0, 32'h0000_0010, 16'hFFFF, 2'b11, 3, 16'h1234, 1'b0, w);
        check("b2b_accept_wait", w, 0);
        check("rd_rdata_lit", rsp_rdata, 16'h1234);

        $display("[TB] slave error then normal read");
        do_cmd(1'b1, 32'h0000_0024, 16'h0F0F, 2'b01, 1, 16'hBEEF, 1'b1, w);
        check("slverr_lit", rsp_err, 1);
        check("slverr_rdata_lit", rsp_rdata, 16'h0000);
        do_cmd(1'b0, 32'h0000_0014, 16'h0000, 2'b00, 0, 16'h5AA5, 1'b0, w);
        check("after_err_accept_wait", w, 0);
        check("after_err_err_lit", rsp_err, 0);
        check("after_err_rdata_lit", rsp_rdata, 16'h5AA5);
        repeat (3) @(negedge clk);

        $display("[TB] busy hold");
        @(posedge clk);
        #1 busy = 1'b1;
        @(posedge clk);
        #1 applyStimulus(1'b1, 32'h0000_0028, 16'h1357, 2'b10, 0, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_ready", cmd_ready, 0);
            check("busy_psel", psel, 0);
        end
        @(posedge clk);
        #1 busy = 1'b0;
        @(negedge clk);
        check("busy_release_n0", cmd_ready, 0);
        @(negedge clk);
        check("busy_release_n1", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checkOutput(latency(0));

        $display("[TB] withdrawn command");
        @(posedge clk);
        #1 busy = 1'b1;
        @(posedge clk);
        #1 begin
            cmd_write = 1'b1;
            cmd_addr  = 32'h0000_002C;
            cmd_valid = 1'b1;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 busy = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen += int'(psel);
        end
        check("withdrawn_no_launch", seen, 0);

        $display("[TB] reset during ACCESS");
        @(posedge clk);
        #1 applyStimulus(1'b0, 32'h0000_0030, 16'h0000, 2'b00, 100, 16'h7777, 1'b0);
        wait_accept(w);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_penable", penable, 1);
        #2;
        rst_n = 1'b0;
        exp_apb.delete();
        exp_rsp.delete();
        #1;
        check("async_psel", psel, 0);
        check("async_penable", penable, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_reset", cmd_ready, 1);
        do_cmd(1'b0, 32'h0000_0034, 16'h0000, 2'b00, 2, 16'hC3C3, 1'b0, w);
        check("post_reset_rdata_lit", rsp_rdata, 16'hC3C3);

`ifdef MATMUL_APB_TIMEOUT_EN
        $display("[TB] ACCESS timeout");
        do_cmd(1'b0, 32'h0000_0040, 16'h0000, 2'b00, 1000, 16'h9999, 1'b0, w);
        check("timeout_err_lit", rsp_err, 1);
        check("timeout_rdata_lit", rsp_rdata, 16'h0000);
        do_cmd(1'b0, 32'h0000_0044, 16'h0000, 2'b00, TO - 1, 16'h4242, 1'b0, w);
        check("limit_ready_wins", rsp_rdata, 16'h4242);
        check("limit_ready_err", rsp_err, 0);
`endif

        repeat (3) @(negedge clk);
        report();
    end

endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- Upstream driver for the matmul accelerator's APB slave port.
- Accepts single read/write commands on a simple valid/ready interface and converts each into one APB3/APB4 transfer (SETUP then ACCESS). Returns read data and error status as a one-cycle response pulse.
- Holds off new transfers while the accelerator reports busy. Sits between the system/testbench sequencer and the matmul top.

Parameters:
- DATA_WIDTH, 8, matrix element width; used only to derive strobe width.
- BUS_WIDTH, 16, APB data width.
- ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with the optional feature.
- Derived localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH, which is the strobe width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_strb_i  in  MAX_DIM  write byte strobes
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes)
- rsp_err_o  out  1  slave error or timeout
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pstrb_o  out  MAX_DIM  APB strobes
- pwdata_o  out  BUS_WIDTH  APB write data
- paddr_o  out  ADDR_WIDTH  APB address
- pready_i  in  1  slave ready
- pslverr_i  in  1  slave error
- prdata_i  in  BUS_WIDTH  slave read data
- busy_i  in  1  accelerator busy (calculation running)

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_ni is asynchronous and active-low.
  - On reset, all outputs go to 0 immediately, including cmd_ready_o, and the FSM enters IDLE.
  - Reset mid-transfer aborts it with no response.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = !busy_i (registered from the previous cycle's busy_i).
  - On cmd_valid_i & cmd_ready_o, latch write/addr/wdata/strb and go to SETUP.
  - For reads, pwdata_o and pstrb_o are driven 0.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0; paddr_o, pwrite_o, pwdata_o, pstrb_o valid.
  - Next state is ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; all APB signals held stable.
  - Stay while pready_i=0.
  - When pready_i=1 is sampled: capture prdata_i (reads only, else 0) and pslverr_i, drop psel_o/penable_o, go to RESP.
- RESP (exactly 1 cycle):
  - rsp_valid_o=1 with rsp_rdata_o and rsp_err_o.
  - Next state is IDLE.
  - rsp_rdata_o and rsp_err_o hold their values until the next response.
- Minimum transfer period: 4 cycles (accept, SETUP, ACCESS with pready_i=1, RESP). Back-to-back commands are allowed from the IDLE cycle after RESP.
- busy_i:
  - Sampled only in IDLE.
  - A transfer already in SETUP/ACCESS completes regardless of busy_i.
  - A command pending while busy_i=1 waits with cmd_ready_o=0.
- cmd_valid_i may be withdrawn before acceptance; nothing is launched in that case.
- pslverr_i is ignored unless pready_i=1 in ACCESS.
- No internal buffering beyond one latched command; there is no response backpressure.

Optional Feature:
- Macro: MATMUL_APB_TIMEOUT_EN.
- Defined:
  - An ACCESS-phase counter clears on SETUP entry and increments each ACCESS cycle with pready_i=0.
  - On reaching TIMEOUT_CYCLES, the transfer is abandoned: psel_o/penable_o drop, then RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - pready_i arriving in the same cycle as the limit wins as a normal completion.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

Decomposition:
- Shared package/header:
  - State encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3).
  - MAX_DIM derivation.
  - Shared defaults for DATA_WIDTH/BUS_WIDTH/ADDR_WIDTH, so the matmul top and this master agree.
- Sub-module: apb_timeout_counter, instantiated only under MATMUL_APB_TIMEOUT_EN. Ports: clear, count-enable, limit-hit.

Test Plan:
- Write: cmd write, addr 0x0000_0020, wdata 0xA55A, strb 2'b11; pready_i=1 on the first ACCESS -> SETUP with psel=1/penable=0, then ACCESS with penable=1; rsp_valid_o pulses 1 cycle with rsp_err_o=0; total 4 cycles.
- Read with wait states: cmd read, addr 0x0000_0010; pready_i low for 3 ACCESS cycles then high with prdata_i=0x1234 -> APB signals stable throughout ACCESS; rsp_rdata_o=0x1234, pstrb_o=0, pwdata_o=0.
- Slave error: write with pslverr_i=1 at pready_i -> rsp_err_o=1; the next command is still accepted normally.
- Busy hold: busy_i=1 while cmd_valid_i=1 -> cmd_ready_o=0 and psel_o=0 for 10 cycles; busy_i falls -> transfer starts 1 cycle later.
- Reset mid-ACCESS: rst_ni low during ACCESS -> psel_o, penable_o, rsp_valid_o go to 0 asynchronously; no response; IDLE after release.
- Timeout (macro defined, TIMEOUT_CYCLES=16): pready_i held 0 -> after 16 ACCESS cycles, psel_o drops and rsp_err_o=1 with rsp_rdata_o=0.
